multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. It is the producer side of the ALU control interface: it sequences each instruction through fetch/decode/execute/memory/writeback and drives aluOP. It drives the datapath mux selects and write enables, samples the ALU zero flag for branches, and counts retired instructions.

Parameters:
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  opcode field, IR[31:26]
zero  input  1  ALU zero flag; valid only while aluOP=01
aluOP  output  2  to ALU: 00 add, 01 subtract (sets zero), 10 use funct
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump address
pc_en  output  1  PC write enable = pc_write | (branch & zero)
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  data memory write enable
ir_write  output  1  instruction register write enable
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=memory data
reg_write  output  1  register file write enable
instr_done  output  1  high in the last state of each instruction
retired  output  RETIRE_W  count of completed instructions
state  output  4  current state, for debug

Behaviour:
- Reset is asynchronous: state<=FETCH and retired<=0 immediately. While reset=1, all enables (pc_en, ir_write, mem_write, reg_write) are forced to 0. All other outputs take FETCH values.
- Outputs are decoded combinationally from the state register only; zero affects pc_en only.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, ADDI_EX=9, ADDI_WB=10, J_EX=11.
- Per-state outputs. Any output not listed is 0 in that state.
  - FETCH: alu_src_b=01, aluOP=00, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_b=11, aluOP=00.
  - MEMADR: alu_src_a=1, alu_src_b=10, aluOP=00.
  - MEMRD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1.
  - MEMWR: iord=1, mem_write=1, instr_done=1.
  - RTYPE_EX: alu_src_a=1, aluOP=10.
  - RTYPE_WB: reg_dst=1, reg_write=1, instr_done=1.
  - BEQ_EX: alu_src_a=1, aluOP=01, pc_src=01, branch=1, instr_done=1.
  - ADDI_EX: alu_src_a=1, alu_src_b=10.
  - ADDI_WB: reg_write=1, instr_done=1.
  - J_EX: pc_src=10, pc_write=1, instr_done=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011 lw or 101011 sw -> MEMADR.
    - 000000 R-type -> RTYPE_EX.
    - 000100 beq -> BEQ_EX.
    - 001000 addi -> ADDI_EX.
    - 000010 j -> J_EX.
    - any other op -> FETCH (treated as nop; instr_done=1 in DECODE for this case only).
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB.
  - RTYPE_EX -> RTYPE_WB.
  - ADDI_EX -> ADDI_WB.
  - MEMWB, MEMWR, RTYPE_WB, BEQ_EX, ADDI_WB, J_EX -> FETCH.
  - Encodings 12-15 -> FETCH, with all enables 0 and instr_done=0.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- op is sampled only in DECODE and MEMADR. The IR is stable after FETCH.
- zero is sampled only in BEQ_EX. Its value in any other state must not affect any output.
- retired increments by 1 on each rising edge where instr_done=1 and reset=0. It wraps modulo 2^RETIRE_W without saturation.
- Reset asserted mid-instruction aborts the instruction: no further enables, retired cleared, FETCH on the first clock after release.

Test Plan:
- reset=1 mid-RTYPE_EX -> state=0, retired=0, all enables 0 without a clock edge; after release, the next edge gives state=1.
- op=100011 from FETCH -> states 0,1,2,3,4; MEMWB has mem_to_reg=1 and reg_write=1; MEMRD has iord=1; retired +1 after 5 cycles.
- op=000000 -> RTYPE_EX has aluOP=10, alu_src_a=1, alu_src_b=00; RTYPE_WB has reg_dst=1, reg_write=1; 4 cycles total.
- op=000100 with zero=1 in BEQ_EX -> pc_en=1, pc_src=01, aluOP=01. Repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- op=000010 -> J_EX has pc_src=10, pc_en=1. Then op=111111 -> DECODE returns to FETCH with no enables and retired +1.
- RETIRE_W=4, 16 consecutive j instructions -> retired wraps 15->0. Force state=13 -> next state 0 with enables 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic                zero,
  output logic [1:0]          aluOP,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    J_EX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   known_op;
  logic   pc_write, branch, ir_wr, mem_wr, reg_wr;

  assign known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTYPE_EX;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = J_EX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = MEMWB;
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
  end

  // Moore decode; undefined encodings fall through to all-zero outputs
  always_comb begin
    aluOP      = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_wr     = 1'b1;
        pc_write  = 1'b1;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        instr_done = !known_op;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        instr_done = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        aluOP     = 2'b10;
      end
      RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      BEQ_EX: begin
        alu_src_a  = 1'b1;
        aluOP      = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      J_EX: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are squashed while reset is held so an aborted instruction has no side effects
  assign pc_en     = !reset && (pc_write || (branch && zero));
  assign ir_write  = !reset && ir_wr;
  assign mem_write = !reset && mem_wr;
  assign reg_write = !reset && reg_wr;
  assign state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retired <= '0;
    else if (instr_done) retired <= retired + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluOP;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done;
  logic [3:0] retired;
  logic [3:0] state;

  int nChecks = 0;
  int nFail   = 0;

  logic [22:0] expQ[$];
  string       nameQ[$];
  logic [3:0]  retCnt;

  multicycle_ctrl #(.RETIRE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .aluOP(aluOP), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: state, aluOP, src_a, src_b, pc_src, 8 enables/flags, retired
  function automatic logic [22:0] actual();
    return {state, aluOP, alu_src_a, alu_src_b, pc_src,
            pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done,
            retired};
  endfunction

  task automatic checkOutput(input string nm, input logic [22:0] act, input logic [22:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // en = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done}
  task automatic pushExp(input string nm, input logic [3:0] st, input logic [1:0] aop,
                         input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                         input logic [7:0] en);
    expQ.push_back({st, aop, sa, sb, ps, en, retCnt});
    nameQ.push_back(nm);
    if (en[0]) retCnt = retCnt + 4'd1;
  endtask

  task automatic waitDrain(input string nm);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0) done = 1;
    end
    if (!done) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL %s_timeout: %0d entries left, expected 0", nm, expQ.size());
      expQ.delete();
      nameQ.delete();
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH
  task automatic applyStimulus(input logic [5:0] opc, input logic z, input string nm);
    op   = opc;
    zero = z;
    pushExp({nm, "_fetch"}, 4'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'b1001_0000);
    case (opc)
      6'b100011: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_memadr"}, 4'd2, 2'b00, 1'b1, 2'b10, 2'b00, 8'b0000_0000);
        pushExp({nm, "_memrd"},  4'd3, 2'b00, 1'b0, 2'b00, 2'b00, 8'b0100_0000);
        pushExp({nm, "_memwb"},  4'd4, 2'b00, 1'b0, 2'b00, 2'b00, 8'b0000_0111);
      end
      6'b101011: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_memadr"}, 4'd2, 2'b00, 1'b1, 2'b10, 2'b00, 8'b0000_0000);
        pushExp({nm, "_memwr"},  4'd5, 2'b00, 1'b0, 2'b00, 2'b00, 8'b0110_0001);
      end
      6'b000000: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_rex"},    4'd6, 2'b10, 1'b1, 2'b00, 2'b00, 8'b0000_0000);
        pushExp({nm, "_rwb"},    4'd7, 2'b00, 1'b0, 2'b00, 2'b00, 8'b0000_1011);
      end
      6'b000100: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_beq"},    4'd8, 2'b01, 1'b1, 2'b00, 2'b01, {z, 7'b000_0001});
      end
      6'b001000: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_addiex"}, 4'd9, 2'b00, 1'b1, 2'b10, 2'b00, 8'b0000_0000);
        pushExp({nm, "_addiwb"}, 4'd10, 2'b00, 1'b0, 2'b00, 2'b00, 8'b0000_0011);
      end
      6'b000010: begin
        pushExp({nm, "_decode"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
        pushExp({nm, "_jex"},    4'd11, 2'b00, 1'b0, 2'b00, 2'b10, 8'b1000_0001);
      end
      default:
        pushExp({nm, "_decode_nop"}, 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0001);
    endcase
    waitDrain(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected vector per clock while the queue holds entries
  always @(negedge clk) begin
    if (!reset && expQ.size() > 0) begin
      logic [22:0] e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(n, actual(), e);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset  = 1'b1;
    op     = 6'd0;
    zero   = 1'b0;
    retCnt = 4'd0;
    #2;
    checkOutput("reset_state", {15'd0, state, retired},
                {15'd0, 4'd0, 4'd0});
    checkOutput("reset_enables", {19'd0, pc_en, ir_write, mem_write, reg_write}, 23'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(6'b100011, 1'b1, "lw");
    applyStimulus(6'b101011, 1'b1, "sw");
    applyStimulus(6'b000000, 1'b1, "rtype");
    applyStimulus(6'b000100, 1'b1, "beq_taken");
    applyStimulus(6'b000100, 1'b0, "beq_nottaken");
    applyStimulus(6'b001000, 1'b1, "addi");
    applyStimulus(6'b000010, 1'b0, "j");
    applyStimulus(6'b111111, 1'b1, "unknown");

    // Abort an R-type in RTYPE_EX with an asynchronous reset between clock edges
    op   = 6'b000000;
    zero = 1'b1;
    pushExp("abort_fetch",  4'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'b1001_0000);
    pushExp("abort_decode", 4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 8'b0000_0000);
    waitDrain("abort");
    @(posedge clk);
    #1;
    checkOutput("pre_abort_state", {19'd0, state}, {19'd0, 4'd6});
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_state_retired", {15'd0, state, retired}, {15'd0, 4'd0, 4'd0});
    checkOutput("abort_enables", {19'd0, pc_en, ir_write, mem_write, reg_write}, 23'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    retCnt = 4'd0;

    // Sixteen jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) applyStimulus(6'b000010, 1'b1, "jwrap");
    applyStimulus(6'b111111, 1'b0, "after_wrap");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
